// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage owning the PC; optional FETCH_PERF_CNT_EN adds perf counters
module if_fetch_unit #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter logic [ADDR_BITS-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [ADDR_BITS-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [ADDR_BITS-1:0] imem_addr,
    input  logic                 imem_ready,
    input  logic [DATA_BITS-1:0] imem_rdata,
    output logic [ADDR_BITS-1:0] if_pc,
    output logic [DATA_BITS-1:0] if_instr,
    output logic                 if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] pc;
    logic [DATA_BITS-1:0] hold_instr;
    logic [ADDR_BITS-1:0] pend_pc;

    // Redirect targets are always word aligned.
    logic [ADDR_BITS-1:0] target_pc;
    logic [ADDR_BITS-1:0] pc_next_seq;
    assign target_pc   = {redirect_pc[ADDR_BITS-1:2], 2'b00};
    assign pc_next_seq = pc + ADDR_BITS'(4);

    // Outputs are decoded from state; FETCH passes memory data straight through.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        if_pc     = pc;
        if_instr  = '0;
        if_valid  = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if_instr = imem_rdata;
                if_valid = imem_ready & ~redirect;
            end
            HOLD: begin
                if_instr = hold_instr;
                if_valid = ~redirect;
            end
            DRAIN: begin
                imem_req = 1'b1;
            end
            default: ;
        endcase
    end

    // Fetch state machine: PC advance, stall holding and redirect draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            hold_instr <= '0;
            pend_pc    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (redirect)
                        pc <= target_pc;
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        if (redirect) begin
                            pc <= target_pc;
                        end else if (!stall) begin
                            pc <= pc_next_seq;
                        end else begin
                            hold_instr <= imem_rdata;
                            state      <= HOLD;
                        end
                    end else if (redirect) begin
                        // The outstanding request must complete before the new target is fetched.
                        pend_pc <= target_pc;
                        state   <= DRAIN;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target_pc;
                        state <= FETCH;
                    end else if (!stall) begin
                        pc    <= pc_next_seq;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        pc    <= redirect ? target_pc : pend_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        pend_pc <= target_pc;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_cycle;
    assign stall_cycle = ((state == HOLD) & stall) |
                         (((state == FETCH) | (state == DRAIN)) & imem_req & ~imem_ready);

    // Accepted-instruction and stall-cycle counters, free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (if_valid & ~stall & ~redirect)
                perf_fetched <= perf_fetched + 32'd1;
            if (stall_cycle)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int lat = 1;
    int wait_cnt;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_valid    (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: ready after lat cycles of an outstanding request.
    assign imem_ready = imem_req && (wait_cnt >= lat - 1);
    assign imem_rdata = (imem_addr == 32'h8) ? 32'hDEAD_BEEF : ~imem_addr;

    always @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= 0;
        else if (imem_req && !imem_ready)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;

        // Reset state
        sample();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, 32'h0);

        // BOOT cycle after release
        next_cycle();
        rst = 1'b0;
        sample();
        check("boot_req", 32'(imem_req), 32'd0);
        check("boot_valid", 32'(if_valid), 32'd0);

        // Sequential fetch with single-cycle memory
        next_cycle();
        sample();
        check("seq0_valid", 32'(if_valid), 32'd1);
        check("seq0_pc", if_pc, 32'h0);
        check("seq0_instr", if_instr, 32'hFFFF_FFFF);
        next_cycle();
        sample();
        check("seq4_valid", 32'(if_valid), 32'd1);
        check("seq4_pc", if_pc, 32'h4);

        // Stall on the word at pc=8
        next_cycle();
        stall = 1'b1;
        sample();
        check("seq8_pc", if_pc, 32'h8);
        check("seq8_instr", if_instr, 32'hDEAD_BEEF);
        check("seq8_valid", 32'(if_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            check("hold_instr", if_instr, 32'hDEAD_BEEF);
            check("hold_pc", if_pc, 32'h8);
            check("hold_valid", 32'(if_valid), 32'd1);
            check("hold_req", 32'(imem_req), 32'd0);
        end
        next_cycle();
        stall = 1'b0;
        sample();
        check("release_valid", 32'(if_valid), 32'd1);
        check("release_pc", if_pc, 32'h8);

        // Latency-3 memory, redirect on the first request cycle
        next_cycle();
        lat = 3;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        sample();
        check("fetchC_addr", imem_addr, 32'hC);
        check("fetchC_req", 32'(imem_req), 32'd1);
        check("fetchC_valid", 32'(if_valid), 32'd0);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("drain1_addr", imem_addr, 32'hC);
        check("drain1_req", 32'(imem_req), 32'd1);
        check("drain1_valid", 32'(if_valid), 32'd0);
        next_cycle();
        sample();
        check("drain2_ready", 32'(imem_ready), 32'd1);
        check("drain2_addr", imem_addr, 32'hC);
        check("drain2_valid", 32'(if_valid), 32'd0);

        // Fetch at redirected target, then stall into HOLD
        next_cycle();
        lat = 1;
        stall = 1'b1;
        sample();
        check("tgt_addr", imem_addr, 32'h100);
        check("tgt_valid", 32'(if_valid), 32'd1);

        // Redirect and stall together in HOLD
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        sample();
        check("hold_redir_valid", 32'(if_valid), 32'd0);
        check("hold_redir_req", 32'(imem_req), 32'd0);
        next_cycle();
        redirect = 1'b0;
        stall = 1'b0;
        sample();
        check("redir200_addr", imem_addr, 32'h200);
        check("redir200_valid", 32'(if_valid), 32'd1);

        // Redirect to top of address space, then wrap
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        sample();
        check("pre_wrap_addr", imem_addr, 32'h204);
        check("pre_wrap_valid", 32'(if_valid), 32'd0);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        check("top_valid", 32'(if_valid), 32'd1);

        // Wrapped fetch with latency-5 memory, redirect into DRAIN
        next_cycle();
        lat = 5;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0040;
        sample();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_valid", 32'(if_valid), 32'd0);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("drain5_req", 32'(imem_req), 32'd1);

        // Reset mid-DRAIN: outputs drop immediately
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_valid", 32'(if_valid), 32'd0);
        check("arst_pc", if_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("arst_perf_fetched", perf_fetched, 32'd0);
        check("arst_perf_stall", perf_stall, 32'd0);
`endif
        next_cycle();
        rst = 1'b0;
        lat = 1;
        sample();
        check("reboot_req", 32'(imem_req), 32'd0);
        next_cycle();
        sample();
        check("resume_addr", imem_addr, 32'h0);
        check("resume_valid", 32'(if_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
